// File: rtl/hamming_stream_decoder.sv
// rtl/hamming_stream_decoder.sv - serial Hamming(7,4) decoder with single-error correction and output backpressure
// Optional macro HAMMING_ERR_CNT_EN builds a saturating counter of corrected blocks on err_cnt.
module hamming_stream_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_bit,
    input  logic             v_vld,
    output logic             v_rdy,
    output logic [3:0]       w,
    output logic [2:0]       s,
    output logic             corr,
    output logic             w_vld,
    input  logic             w_rdy,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_cnt;
    logic [6:0] r_buf;
    logic [3:0] r_w;
    logic [2:0] r_s;
    logic       r_corr;
    logic       r_wvld;

    logic       w_accept;
    logic       w_last;
    logic       w_out_free;
    logic       w_load;
    logic [6:0] w_raw;
    logic [2:0] w_syn;
    logic [6:0] w_flip;
    logic [6:0] w_fixed;

    assign w_accept   = v_vld && (r_state == COLLECT);
    assign w_last     = w_accept && (r_cnt == 3'd6);
    assign w_out_free = !r_wvld || w_rdy;
    assign w_load     = (w_last && w_out_free) || ((r_state == STALL) && w_rdy);

    // In STALL the whole block already sits in r_buf; otherwise the seventh bit is still on the wire.
    assign w_raw = (r_state == STALL) ? r_buf : {v_bit, r_buf[5:0]};

    assign w_syn[0] = w_raw[0] ^ w_raw[2] ^ w_raw[4] ^ w_raw[6];
    assign w_syn[1] = w_raw[1] ^ w_raw[2] ^ w_raw[5] ^ w_raw[6];
    assign w_syn[2] = w_raw[3] ^ w_raw[4] ^ w_raw[5] ^ w_raw[6];

    always_comb begin
        w_flip = 7'd0;
        if (w_syn != 3'd0) begin
            w_flip[w_syn - 3'd1] = 1'b1;
        end
    end

    assign w_fixed = w_raw ^ w_flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: if (w_last && !w_out_free) w_next_state = STALL;
            STALL:   if (w_rdy) w_next_state = COLLECT;
            default: w_next_state = COLLECT;
        endcase
    end

    always_comb begin
        v_rdy = (r_state == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 3'd0;
            r_buf  <= 7'd0;
            r_w    <= 4'd0;
            r_s    <= 3'd0;
            r_corr <= 1'b0;
            r_wvld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf[r_cnt] <= v_bit;
                r_cnt        <= (r_cnt == 3'd6) ? 3'd0 : r_cnt + 3'd1;
            end
            if (w_load) begin
                r_w    <= {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
                r_s    <= w_syn;
                r_corr <= (w_syn != 3'd0);
                r_wvld <= 1'b1;
            end else if (w_rdy) begin
                r_wvld <= 1'b0;
            end
        end
    end

    assign w     = r_w;
    assign s     = r_s;
    assign corr  = r_corr;
    assign w_vld = r_wvld;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_load && (w_syn != 3'd0) && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: doc/hamming_stream_decoder.md
HAMMING_STREAM_DECODER -- requirements
Module: hamming_stream_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the corrected-block counter err_cnt.
REQ-002 Port: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1; reset is synchronous and active-high.
REQ-004 Port: v_bit, input, 1, serial received codeword bit.
REQ-005 Port: v_vld, input, 1, v_bit valid; a bit is accepted when v_vld && v_rdy.
REQ-006 Port: v_rdy, output, 1, block can accept a bit this cycle.
REQ-007 Port: w, output, 4, recovered data nibble.
REQ-008 Port: s, output, 3, syndrome (error position 1..7, 0 = no error).
REQ-009 Port: corr, output, 1, high when s != 0.
REQ-010 Port: w_vld, output, 1, w/s/corr valid.
REQ-011 Port: w_rdy, input, 1, consumer accepts; a transfer occurs when w_vld && w_rdy.
REQ-012 Port: err_cnt, output, CNT_W, count of delivered blocks with s != 0.

Function
REQ-013 Bits shall be assembled LSB first: the first accepted bit is v[0], the seventh is v[6].
REQ-014 Code mapping: v[i] is position i+1; parity at v[0],v[1],v[3]; data u0..u3 at v[2],v[4],v[5],v[6].
REQ-015 Syndrome: s[0]=v0^v2^v4^v6, s[1]=v1^v2^v5^v6, s[2]=v3^v4^v5^v6.
REQ-016 Correction: d = v with bit v[s-1] inverted when s != 0; w = {d[6],d[5],d[4],d[2]}.
REQ-017 A 3-bit bit counter shall track 0..6 and wrap to 0 after the seventh accepted bit.
REQ-018 FSM states: COLLECT (v_rdy=1) and STALL (v_rdy=0).
REQ-019 On acceptance of the seventh bit, if the output register is empty or transferring that cycle, the decoded block shall load into the output register; w_vld rises the next cycle (latency 1 clock).
REQ-020 On acceptance of the seventh bit with the output register full and w_rdy low, the raw block shall be held and the FSM shall enter STALL.
REQ-021 In STALL, on the cycle w_rdy is high the held block shall be decoded into the output register and the FSM shall return to COLLECT; w_vld stays high.
REQ-022 w_vld shall fall after a transfer only when no new block loads in that same cycle.
REQ-023 w, s and corr shall be stable while w_vld && !w_rdy.
REQ-024 Bits with v_vld low shall be ignored; gaps between bits are allowed at any position.
REQ-025 A double-bit error shall be miscorrected per REQ-016 without any flag; no detection beyond a single error.

Reset
REQ-026 rst shall set FSM=COLLECT, bit counter=0, w_vld=0, w=0, s=0, corr=0, err_cnt=0.
REQ-027 rst mid-block or in STALL shall discard the partial or held block; the first bit accepted after rst is v[0].
REQ-028 rst shall take priority over every simultaneous event.

Configuration
REQ-029 Macro HAMMING_ERR_CNT_EN shall compile in err_cnt.
REQ-030 With HAMMING_ERR_CNT_EN, err_cnt shall increment by 1 when a block with s != 0 loads into the output register and saturate at all ones.
REQ-031 Without HAMMING_ERR_CNT_EN, err_cnt shall be constant 0 and no counter flops shall exist.

Verification
REQ-032 Bits of 7'b0000000, w_rdy=1 -> w=4'b0000, s=0, corr=0, w_vld high 1 cycle after the 7th bit.
REQ-033 Bits of 7'b1010101 with v[4] flipped (7'b1000101) -> w=4'b1011, s=3'd5, corr=1, err_cnt=1.
REQ-034 Sweep all 16 data values x (no error + each of 7 single errors) -> w equals sent data every time, s equals flipped position, err_cnt=112 (CNT_W=8).
REQ-035 w_rdy=0, two blocks streamed -> first held on w, v_rdy=0 after the 14th bit; raise w_rdy -> second block appears the next cycle, v_rdy=1.
REQ-036 rst asserted after 4 bits, then 7'b1010101 streamed -> w=4'b1011, s=0; no trace of the partial block.
REQ-037 Build without HAMMING_ERR_CNT_EN, run REQ-033 stimulus -> err_cnt=0, decode unchanged.
